pipeline_ctrl: RTL and testbench

//   Sequencing controller for the five-stage pipeline (IF/ID/EXE/MEM/WB).
//   - Owns the per-stage valid bits and computes each stage's allow-in.
//   - Drives IF_valid and next_fetch into the fetch stage, plus the inter-stage bus latch enables.
//   - Flushes the pipe on an exception.
//   - Keeps cycle, retired-instruction and fetch-stall counters for the display.

---
 rtl/pipeline_ctrl.sv | 81 ++++++++
 tb/tb_pipeline_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Sequencing controller for the five-stage IF/ID/EXE/MEM/WB pipeline:
// stage valid bits, allow-in chain, bus latch enables, flush and perf counters.
module pipeline_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             IF_over,
    input  logic             ID_over,
    input  logic             EXE_over,
    input  logic             MEM_over,
    input  logic             WB_over,
    input  logic             exc_valid,
    output logic             IF_valid,
    output logic             ID_valid,
    output logic             EXE_valid,
    output logic             MEM_valid,
    output logic             WB_valid,
    output logic             next_fetch,
    output logic             IF_ID_en,
    output logic             ID_EXE_en,
    output logic             EXE_MEM_en,
    output logic             MEM_WB_en,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    logic wb_ai;
    logic mem_ai;
    logic exe_ai;
    logic id_ai;

    // Backpressure chain: a stage accepts when empty or when it drains this cycle.
    assign wb_ai  = !WB_valid  | WB_over;
    assign mem_ai = !MEM_valid | (MEM_over & wb_ai);
    assign exe_ai = !EXE_valid | (EXE_over & mem_ai);
    assign id_ai  = !ID_valid  | (ID_over  & exe_ai);

    // A redirect kills every bus transfer in its cycle.
    assign IF_ID_en   = !exc_valid & IF_valid  & IF_over  & id_ai;
    assign ID_EXE_en  = !exc_valid & ID_valid  & ID_over  & exe_ai;
    assign EXE_MEM_en = !exc_valid & EXE_valid & EXE_over & mem_ai;
    assign MEM_WB_en  = !exc_valid & MEM_valid & MEM_over & wb_ai;

    assign next_fetch = IF_ID_en | exc_valid;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            IF_valid   <= 1'b0;
            ID_valid   <= 1'b0;
            EXE_valid  <= 1'b0;
            MEM_valid  <= 1'b0;
            WB_valid   <= 1'b0;
            cycle_cnt  <= '0;
            retire_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            IF_valid  <= 1'b1;
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (WB_valid & WB_over) begin
                retire_cnt <= retire_cnt + CNT_W'(1);
            end
            if (IF_valid & IF_over & !id_ai & !exc_valid) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (exc_valid) begin
                ID_valid  <= 1'b0;
                EXE_valid <= 1'b0;
                MEM_valid <= 1'b0;
                WB_valid  <= 1'b0;
            end else begin
                if (id_ai)  ID_valid  <= IF_ID_en;
                if (exe_ai) EXE_valid <= ID_EXE_en;
                if (mem_ai) MEM_valid <= EXE_MEM_en;
                if (wb_ai)  WB_valid  <= MEM_WB_en;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: occupancy-vector reference model,
// per-cycle compare of two builds (32-bit and 4-bit counters), directed literals.
module tb_pipeline_ctrl;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic IF_over = 1'b0, ID_over = 1'b0, EXE_over = 1'b0, MEM_over = 1'b0, WB_over = 1'b0;
    logic exc_valid = 1'b0;

    logic IF_valid, ID_valid, EXE_valid, MEM_valid, WB_valid, next_fetch;
    logic IF_ID_en, ID_EXE_en, EXE_MEM_en, MEM_WB_en;
    logic [31:0] cycle_cnt, retire_cnt, stall_cnt;

    logic f_IF_valid, f_ID_valid, f_EXE_valid, f_MEM_valid, f_WB_valid, f_next_fetch;
    logic f_IF_ID_en, f_ID_EXE_en, f_EXE_MEM_en, f_MEM_WB_en;
    logic [3:0] f_cycle_cnt, f_retire_cnt, f_stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .clk(clk), .resetn(resetn),
        .IF_over(IF_over), .ID_over(ID_over), .EXE_over(EXE_over),
        .MEM_over(MEM_over), .WB_over(WB_over), .exc_valid(exc_valid),
        .IF_valid(IF_valid), .ID_valid(ID_valid), .EXE_valid(EXE_valid),
        .MEM_valid(MEM_valid), .WB_valid(WB_valid), .next_fetch(next_fetch),
        .IF_ID_en(IF_ID_en), .ID_EXE_en(ID_EXE_en), .EXE_MEM_en(EXE_MEM_en),
        .MEM_WB_en(MEM_WB_en), .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt),
        .stall_cnt(stall_cnt)
    );

    pipeline_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .resetn(resetn),
        .IF_over(IF_over), .ID_over(ID_over), .EXE_over(EXE_over),
        .MEM_over(MEM_over), .WB_over(WB_over), .exc_valid(exc_valid),
        .IF_valid(f_IF_valid), .ID_valid(f_ID_valid), .EXE_valid(f_EXE_valid),
        .MEM_valid(f_MEM_valid), .WB_valid(f_WB_valid), .next_fetch(f_next_fetch),
        .IF_ID_en(f_IF_ID_en), .ID_EXE_en(f_ID_EXE_en), .EXE_MEM_en(f_EXE_MEM_en),
        .MEM_WB_en(f_MEM_WB_en), .cycle_cnt(f_cycle_cnt), .retire_cnt(f_retire_cnt),
        .stall_cnt(f_stall_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: occupancy vector indexed IF=0 .. WB=4, plus counters.
    logic [4:0]  m_v;
    logic [31:0] m_cyc, m_ret, m_stall;

    function automatic logic [4:0] over_vec();
        return {WB_over, MEM_over, EXE_over, ID_over, IF_over};
    endfunction

    // Stage s can take a new entry if empty, or if its entry and everything ahead move.
    function automatic logic [4:0] model_ai(input logic [4:0] v, input logic [4:0] ov);
        logic [4:0] ai;
        ai = '0;
        for (int s = 4; s >= 1; s--) begin
            if (s == 4) ai[s] = !v[s] | ov[s];
            else        ai[s] = !v[s] | (ov[s] & ai[s+1]);
        end
        return ai;
    endfunction

    // en[s] moves stage s's entry into stage s+1.
    function automatic logic [3:0] model_en(input logic [4:0] v, input logic [4:0] ov, input logic x);
        logic [4:0] ai;
        logic [3:0] en;
        ai = model_ai(v, ov);
        for (int s = 0; s < 4; s++) en[s] = !x & v[s] & ov[s] & ai[s+1];
        return en;
    endfunction

    always @(posedge clk) begin
        logic [4:0] ai;
        logic [3:0] en;
        logic [4:0] ov;
        ov = over_vec();
        if (!resetn) begin
            m_v = '0; m_cyc = '0; m_ret = '0; m_stall = '0;
        end else begin
            ai = model_ai(m_v, ov);
            en = model_en(m_v, ov, exc_valid);
            m_cyc = m_cyc + 1;
            if (m_v[4] && WB_over) m_ret = m_ret + 1;
            if (m_v[0] && IF_over && !ai[1] && !exc_valid) m_stall = m_stall + 1;
            for (int s = 4; s >= 1; s--) begin
                if (exc_valid)  m_v[s] = 1'b0;
                else if (ai[s]) m_v[s] = en[s-1];
            end
            m_v[0] = 1'b1;
        end
    end

    // Per-cycle compare of both builds against the model.
    always @(negedge clk) begin
        logic [3:0] en;
        en = model_en(m_v, over_vec(), exc_valid);
        chk("IF_valid",   {31'b0, IF_valid},   {31'b0, m_v[0]});
        chk("ID_valid",   {31'b0, ID_valid},   {31'b0, m_v[1]});
        chk("EXE_valid",  {31'b0, EXE_valid},  {31'b0, m_v[2]});
        chk("MEM_valid",  {31'b0, MEM_valid},  {31'b0, m_v[3]});
        chk("WB_valid",   {31'b0, WB_valid},   {31'b0, m_v[4]});
        chk("enables",    {28'b0, MEM_WB_en, EXE_MEM_en, ID_EXE_en, IF_ID_en}, {28'b0, en});
        chk("next_fetch", {31'b0, next_fetch}, {31'b0, en[0] | exc_valid});
        chk("cycle_cnt",  cycle_cnt,  m_cyc);
        chk("retire_cnt", retire_cnt, m_ret);
        chk("stall_cnt",  stall_cnt,  m_stall);
        chk("w4_valids", {27'b0, f_WB_valid, f_MEM_valid, f_EXE_valid, f_ID_valid, f_IF_valid},
            {27'b0, m_v});
        chk("w4_enables", {27'b0, f_next_fetch, f_MEM_WB_en, f_EXE_MEM_en, f_ID_EXE_en, f_IF_ID_en},
            {27'b0, en[0] | exc_valid, en});
        chk("w4_cycle_cnt",  {28'b0, f_cycle_cnt},  {28'b0, m_cyc[3:0]});
        chk("w4_retire_cnt", {28'b0, f_retire_cnt}, {28'b0, m_ret[3:0]});
        chk("w4_stall_cnt",  {28'b0, f_stall_cnt},  {28'b0, m_stall[3:0]});
    end

    task automatic tick(input logic r, input logic [4:0] ov, input logic x);
        @(posedge clk);
        #1;
        resetn = r;
        {WB_over, MEM_over, EXE_over, ID_over, IF_over} = ov;
        exc_valid = x;
        @(negedge clk);
    endtask

    initial begin
        logic [4:0] ov;
        // Reset held for three cycles
        repeat (3) tick(1'b0, 5'h1F, 1'b0);
        chk("rst_valids", {27'b0, WB_valid, MEM_valid, EXE_valid, ID_valid, IF_valid}, 32'd0);
        chk("rst_en", {28'b0, MEM_WB_en, EXE_MEM_en, ID_EXE_en, IF_ID_en}, 32'd0);
        chk("rst_cnt", cycle_cnt | retire_cnt | stall_cnt, 32'd0);

        // Free flow: k=0 is the release cycle, k=1 follows the first enabled edge
        tick(1'b1, 5'h1F, 1'b0);
        chk("k0_IF_valid", {31'b0, IF_valid}, 32'd0);
        tick(1'b1, 5'h1F, 1'b0);
        chk("k1_IF_valid", {31'b0, IF_valid}, 32'd1);
        chk("k1_ID_valid", {31'b0, ID_valid}, 32'd0);
        chk("k1_IF_ID_en", {31'b0, IF_ID_en}, 32'd1);
        repeat (3) tick(1'b1, 5'h1F, 1'b0);
        chk("k4_WB_valid", {31'b0, WB_valid}, 32'd0);
        tick(1'b1, 5'h1F, 1'b0);
        chk("k5_WB_valid", {31'b0, WB_valid}, 32'd1);
        chk("k5_retire", retire_cnt, 32'd0);
        repeat (10) tick(1'b1, 5'h1F, 1'b0);
        chk("k15_retire", retire_cnt, 32'd10);
        chk("k15_cycle", cycle_cnt, 32'd15);
        chk("k15_w4_cycle", {28'b0, f_cycle_cnt}, 32'd15);
        tick(1'b1, 5'h1F, 1'b0);
        chk("k16_w4_wrap", {28'b0, f_cycle_cnt}, 32'd0);
        chk("k16_cycle", cycle_cnt, 32'd16);

        // ID hazard for three cycles on a full pipe
        tick(1'b1, 5'b11101, 1'b0);
        chk("haz_IF_ID_en", {31'b0, IF_ID_en}, 32'd0);
        chk("haz_next_fetch", {31'b0, next_fetch}, 32'd0);
        tick(1'b1, 5'b11101, 1'b0);
        chk("haz_bubble", {31'b0, EXE_valid}, 32'd0);
        tick(1'b1, 5'b11101, 1'b0);
        tick(1'b1, 5'h1F, 1'b0);
        chk("haz_stall_cnt", stall_cnt, 32'd3);

        // EXE multicycle, then release
        repeat (4) tick(1'b1, 5'h1F, 1'b0);
        repeat (5) tick(1'b1, 5'b11011, 1'b0);
        chk("mc_MEM_bubble", {31'b0, MEM_valid}, 32'd0);
        chk("mc_backpressure", {31'b0, IF_ID_en}, 32'd0);
        repeat (5) tick(1'b1, 5'h1F, 1'b0);

        // Exception with all four downstream stages full
        chk("pre_exc_full", {28'b0, WB_valid, MEM_valid, EXE_valid, ID_valid}, 32'hF);
        tick(1'b1, 5'h1F, 1'b1);
        chk("exc_next_fetch", {31'b0, next_fetch}, 32'd1);
        chk("exc_en", {28'b0, MEM_WB_en, EXE_MEM_en, ID_EXE_en, IF_ID_en}, 32'd0);
        tick(1'b1, 5'h1F, 1'b0);
        chk("exc_flushed", {27'b0, WB_valid, MEM_valid, EXE_valid, ID_valid, IF_valid}, 32'd1);

        // Randomized traffic with rare exceptions and mid-stream resets
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 5; b++) ov[b] = ($urandom_range(0, 3) != 0);
            tick(($urandom_range(0, 199) != 0), ov, ($urandom_range(0, 19) == 0));
        end

        // Mid-stream reset clears everything at that edge
        repeat (6) tick(1'b1, 5'h1F, 1'b0);
        tick(1'b0, 5'h1F, 1'b0);
        tick(1'b1, 5'h1F, 1'b0);
        chk("mid_rst_valids", {27'b0, WB_valid, MEM_valid, EXE_valid, ID_valid, IF_valid}, 32'd0);
        chk("mid_rst_cnt", cycle_cnt | retire_cnt | stall_cnt, 32'd0);
        tick(1'b1, 5'h1F, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
